data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning byte-address width; depth is 2^ADDR_W bytes.
REQ-002 The block SHALL have parameter LATENCY, default 1, legal 1..15, meaning WAIT cycles between accept and response.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 The block SHALL have port req_func3  input  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-009 The block SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 The block SHALL have port req_wdata  input  32  store data, low bytes used for b/h.
REQ-011 The block SHALL have port rsp_valid  output  1  response present.
REQ-012 The block SHALL have port rsp_ready  input  1  consumer takes response.
REQ-013 The block SHALL have port rsp_rdata  output  32  load result, zero for stores and errors.
REQ-014 The block SHALL have port rsp_err  output  1  illegal func3 or trapped misalignment.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-016 A request SHALL be accepted on an edge with req_valid&&req_ready, latching we/func3/addr/wdata, loading cnt=LATENCY-1, and moving to WAIT.
REQ-017 In WAIT the FSM SHALL decrement cnt while cnt>0; on the edge with cnt==0 it SHALL perform the access, register rsp_rdata/rsp_err and go to RESP.
REQ-018 rsp_valid SHALL rise exactly LATENCY edges after the accepting edge.
REQ-019 In RESP, outputs SHALL hold until an edge with rsp_ready=1, then go to IDLE; no request SHALL be accepted in the same cycle.
REQ-020 Memory SHALL be little-endian with byte k of the access at (addr+k) mod 2^ADDR_W; wrap-around is legal.
REQ-021 Loads SHALL be: b sign-extend byte, h sign-extend halfword, w full word, bu/hu zero-extend.
REQ-022 Stores SHALL write 1/2/4 bytes for func3 000/001/010 only, at the access edge only.
REQ-023 Load func3 011/110/111 and store func3 other than 000/001/010 SHALL set rsp_err=1 and rsp_rdata=0, with no memory write.
REQ-024 Store responses SHALL carry rsp_rdata=0 and rsp_err=0 when legal.

Reset
REQ-025 On rst=1 at an edge the FSM SHALL go to IDLE with cnt=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready SHALL be 1 from the following cycle.
REQ-026 A reset in WAIT or RESP SHALL discard the pending request with no write; rst SHALL take priority over all other events in the same cycle.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro MISALIGN_TRAP_EN defined, halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 SHALL complete with rsp_err=1, rsp_rdata=0, no write, and the same latency.
REQ-029 Without MISALIGN_TRAP_EN, misaligned accesses SHALL complete normally, byte-wise, per REQ-020.

Verification
REQ-030 Store then load: sw 0x800160AA @0x10, then lw @0x10 -> rdata 0x800160AA, err 0; lb @0x10 -> 0xFFFFFFAA; lbu @0x10 -> 0x000000AA; lhu @0x12 -> 0x00008001.
REQ-031 Latency with LATENCY=3: accept at edge N -> rsp_valid=1 after edge N+3; with rsp_ready held 0 for 4 cycles, rsp_valid/rdata stay stable and req_ready stays 0.
REQ-032 Misalignment: lh @0x11 after REQ-030 data -> err=1, rdata 0 with macro; 0x00000160, err 0 without macro.
REQ-033 Wrap, no macro, ADDR_W=8: sw 0x44332211 @0xFE, then lbu @0x01 -> 0x00000044 and lbu @0xFE -> 0x00000011.
REQ-034 Illegal func3: store with func3=100 @0x10 -> err=1; a following lw @0x10 still returns 0x800160AA.
REQ-035 Reset mid-op: sb 0x55 @0x20 accepted, rst in WAIT -> rsp_valid never asserts and a later lbu @0x20 returns the prior value.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port byte-addressed data memory behind a valid/ready
// request/response handshake, supporting RV32 load/store widths.
//
// Each accepted request waits LATENCY clock edges before its response is
// presented; the memory access itself happens on the final wait edge.
//
// Parameters
//   ADDR_W   byte-address width, memory depth is 2**ADDR_W bytes
//   LATENCY  edges from accept to rsp_valid (1..15)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (memory contents are kept)
//   req_valid  request present            req_ready  idle, can accept
//   req_we     1 = store, 0 = load        req_func3  RV32 width code
//   req_addr   byte address               req_wdata  store data (low bytes for b/h)
//   rsp_valid  response present           rsp_ready  consumer takes response
//   rsp_rdata  load result (0 for stores/errors)
//   rsp_err    illegal func3 or trapped misalignment
//
// Build option
//   MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses return
//                     rsp_err=1 with no write; otherwise they complete
//                     byte-wise with address wrap-around.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              we_q;
    logic [2:0]        func3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [7:0]        mem [Depth];

    logic [ADDR_W-1:0] byte_addr [4];
    logic [7:0]        rd_byte [4];
    logic [3:0]        wr_en;
    logic              accept;
    logic              access;
    logic              legal;
    logic              misalign;
    logic              bad;
    logic [31:0]       load_data;

    assign accept = req_valid && (state_q == StIdle);
    assign access = (state_q == StWait) && (cnt_q == 4'd0);

    // Byte lanes of the access; address arithmetic wraps modulo the depth.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = addr_q + ADDR_W'(k);
            rd_byte[k]   = mem[byte_addr[k]];
        end
    end

    always_comb begin
        if (we_q) begin
            legal = (func3_q == 3'b000) || (func3_q == 3'b001) || (func3_q == 3'b010);
        end else begin
            legal = (func3_q == 3'b000) || (func3_q == 3'b001) || (func3_q == 3'b010) ||
                    (func3_q == 3'b100) || (func3_q == 3'b101);
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((func3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((func3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad = !legal || misalign;

    always_comb begin
        load_data = 32'h0;
        case (func3_q)
            3'b000:  load_data = {{24{rd_byte[0][7]}}, rd_byte[0]};
            3'b001:  load_data = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
            3'b010:  load_data = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
            3'b100:  load_data = {24'h0, rd_byte[0]};
            3'b101:  load_data = {16'h0, rd_byte[1], rd_byte[0]};
            default: load_data = 32'h0;
        endcase
    end

    // Byte enables for a legal store: 1, 2 or 4 lanes from func3[1:0].
    always_comb begin
        wr_en = 4'b0000;
        if (access && we_q && !bad) begin
            case (func3_q[1:0])
                2'b00:   wr_en = 4'b0001;
                2'b01:   wr_en = 4'b0011;
                2'b10:   wr_en = 4'b1111;
                default: wr_en = 4'b0000;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = StWait;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                    err_d   = bad;
                    rdata_d = (bad || we_q) ? 32'h0 : load_data;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                func3_q <= req_func3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // Storage is never cleared; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst && wr_en[k]) begin
                mem[byte_addr[k]] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (ADDR_W=8, LATENCY=3): directed
// scenarios plus randomized traffic against a byte-array reference model.
module tb_data_mem_ctrl;

    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_func3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl [256];

    data_mem_ctrl #(
        .ADDR_W (AW),
        .LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_func3(req_func3),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference: memory as a plain byte array, values built arithmetically.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [7:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic er);
        int n;
        bit legal;
        bit mis;
        longint unsigned v;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n = 1 << f3[1:0];
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
`endif
        er = !legal || mis;
        rd = 32'h0;
        if (er) return;
        if (we) begin
            for (int k = 0; k < n; k++) mdl[(int'(a) + k) % 256] = 8'((wd >> (8 * k)) & 32'hFF);
        end else begin
            v = 0;
            for (int k = 0; k < n; k++) v += longint'(mdl[(int'(a) + k) % 256]) << (8 * k);
            if (f3 < 3'd4 && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
                v = v + (64'h1_0000_0000 - (64'h1 << (8 * n)));
            rd = v[31:0];
        end
    endfunction

    // One full transaction; returns response fields and edges from accept to rsp_valid.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic run(input string nm, input logic we, input logic [2:0] f3,
                       input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          lat;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_idle: got %b want 1", nm, req_ready);
        end
        txn(we, f3, a, wd, rd, er, lat);
        model(we, f3, a, wd, exp_rd, exp_er);
        checks += 3;
        if (lat !== int'(LAT)) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, LAT);
        end
        if (rd !== exp_rd) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", nm, rd, exp_rd);
        end
        if (er !== exp_er) begin
            failures++;
            $display("FAIL %s err: got %b want %b", nm, er, exp_er);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b0;
        req_addr = '0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset ready: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset rdata: got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset err: got %b want 0", rsp_err); end
    endtask

    task automatic test_init();
        logic [31:0] rd;
        logic        er;
        for (int w = 0; w < 64; w++) run("init", 1'b1, 3'b010, 8'(w * 4), $urandom, rd, er);
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        run("sw10", 1'b1, 3'b010, 8'h10, 32'h800160AA, rd, er);
        run("lw10", 1'b0, 3'b010, 8'h10, 32'h0, rd, er);
        checks += 2;
        if (rd !== 32'h800160AA) begin failures++; $display("FAIL lw10 const: got %h want 800160aa", rd); end
        if (er !== 1'b0) begin failures++; $display("FAIL lw10 err const: got %b want 0", er); end
        run("lb10", 1'b0, 3'b000, 8'h10, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hFFFFFFAA) begin failures++; $display("FAIL lb10 const: got %h want ffffffaa", rd); end
        run("lbu10", 1'b0, 3'b100, 8'h10, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h000000AA) begin failures++; $display("FAIL lbu10 const: got %h want 000000aa", rd); end
        run("lhu12", 1'b0, 3'b101, 8'h12, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h00008001) begin failures++; $display("FAIL lhu12 const: got %h want 00008001", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er;
        logic [31:0] want_rd;
        logic        want_er;
`ifdef MISALIGN_TRAP_EN
        want_rd = 32'h0; want_er = 1'b1;
`else
        want_rd = 32'h00000160; want_er = 1'b0;
`endif
        run("lh11", 1'b0, 3'b001, 8'h11, 32'h0, rd, er);
        checks += 2;
        if (rd !== want_rd) begin failures++; $display("FAIL lh11 const: got %h want %h", rd, want_rd); end
        if (er !== want_er) begin failures++; $display("FAIL lh11 err const: got %b want %b", er, want_er); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic        er;
        run("swFE", 1'b1, 3'b010, 8'hFE, 32'h44332211, rd, er);
`ifndef MISALIGN_TRAP_EN
        run("lbu01", 1'b0, 3'b100, 8'h01, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h00000044) begin failures++; $display("FAIL lbu01 const: got %h want 44", rd); end
        run("lbuFE", 1'b0, 3'b100, 8'hFE, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h00000011) begin failures++; $display("FAIL lbuFE const: got %h want 11", rd); end
`endif
    endtask

    task automatic test_illegal();
        logic [31:0] rd;
        logic        er;
        run("st100", 1'b1, 3'b100, 8'h10, 32'h12345678, rd, er);
        checks++;
        if (er !== 1'b1) begin failures++; $display("FAIL st100 err const: got %b want 1", er); end
        run("lw10b", 1'b0, 3'b010, 8'h10, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h800160AA) begin failures++; $display("FAIL lw10b const: got %h want 800160aa", rd); end
        run("ld111", 1'b0, 3'b111, 8'h10, 32'h0, rd, er);
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic [31:0] rd;
        logic        er;
        int          lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 8'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks += 2;
        if (lat !== int'(LAT)) begin failures++; $display("FAIL bp latency: got %0d want %0d", lat, LAT); end
        held = rsp_rdata;
        if (held !== 32'h800160AA) begin failures++; $display("FAIL bp rdata: got %h want 800160aa", held); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            // A store offered while busy must never be taken.
            req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b000; req_addr = 8'h10;
            req_wdata = 32'h77;
            checks += 3;
            if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp hold valid: got %b want 1", rsp_valid); end
            if (rsp_rdata !== held) begin failures++; $display("FAIL bp hold rdata: got %h want %h", rsp_rdata, held); end
            if (req_ready !== 1'b0) begin failures++; $display("FAIL bp hold ready: got %b want 0", req_ready); end
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0; req_valid = 1'b0;
        checks += 2;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp release valid: got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin failures++; $display("FAIL bp no same-cycle accept: got %b want 1", req_ready); end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp stray rsp: got %b want 0", rsp_valid); end
        run("bp lw10", 1'b0, 3'b010, 8'h10, 32'h0, rd, er);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        bit          seen;
        run("sb20 pre", 1'b1, 3'b000, 8'h20, 32'h12, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b000; req_addr = 8'h20;
        req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks += 3;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL rstmid ready: got %b want 1", req_ready); end
        if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rstmid rdata: got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin failures++; $display("FAIL rstmid err: got %b want 0", rsp_err); end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL rstmid rsp_valid: got 1 want 0"); end
        run("lbu20", 1'b0, 3'b100, 8'h20, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h00000012) begin failures++; $display("FAIL lbu20 const: got %h want 12", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic        er;
        logic [7:0]  a;
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 259)) : 8'($urandom);
            run("rand", 1'($urandom), 3'($urandom), a, $urandom, rd, er);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_store_load();
        test_misalign();
        test_wrap();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
